// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: fetch port, data port, memory port and status.
// The arbiter uses the slave modport; requesters and the memory use master.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              i_valid;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ready;
    logic              i_flush;
    logic              i_rsp_valid;
    logic [31:0]       i_rsp_data;

    logic              d_valid;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic [3:0]        d_wstrb;
    logic              d_ready;
    logic              d_rsp_valid;
    logic [31:0]       d_rsp_data;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_wstrb;
    logic [31:0]       mem_rdata;

    logic              busy;

    modport slave (
        input  i_valid, i_addr, i_flush,
        input  d_valid, d_we, d_addr, d_wdata, d_wstrb,
        input  mem_rdata,
        output i_ready, i_rsp_valid, i_rsp_data,
        output d_ready, d_rsp_valid, d_rsp_data,
        output mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output busy
    );

    modport master (
        output i_valid, i_addr, i_flush,
        output d_valid, d_we, d_addr, d_wdata, d_wstrb,
        output mem_rdata,
        input  i_ready, i_rsp_valid, i_rsp_data,
        input  d_ready, d_rsp_valid, d_rsp_data,
        input  mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-ported memory between instruction fetch and
// data load/store, with data priority, fetch anti-starvation and flush dropping.
module mem_port_arbiter #(
    parameter int unsigned MEM_LATENCY  = 1,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned ADDR_W       = 32
) (
    input  logic                clk,
    input  logic                rstn,
    mem_port_arbiter_if.slave   bus
);

    localparam int unsigned LAT_W = $clog2(MEM_LATENCY + 1);
    localparam int unsigned SC_W  = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic [SC_W-1:0]   starve_q, starve_d;
    logic              is_data_q, is_data_d;
    logic              we_q, we_d;
    logic              drop_q, drop_d;

    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [3:0]        mem_wstrb_q, mem_wstrb_d;

    logic              i_rsp_valid_q, i_rsp_valid_d;
    logic [31:0]       i_rsp_data_q, i_rsp_data_d;
    logic              d_rsp_valid_q, d_rsp_valid_d;
    logic [31:0]       d_rsp_data_q, d_rsp_data_d;
    logic              busy_q, busy_d;

    logic              i_ready, d_ready;
    logic              starve_full, d_wins;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q       <= IDLE;
            lat_q         <= '0;
            starve_q      <= '0;
            is_data_q     <= 1'b0;
            we_q          <= 1'b0;
            drop_q        <= 1'b0;
            mem_en_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            mem_wstrb_q   <= '0;
            i_rsp_valid_q <= 1'b0;
            i_rsp_data_q  <= '0;
            d_rsp_valid_q <= 1'b0;
            d_rsp_data_q  <= '0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            lat_q         <= lat_d;
            starve_q      <= starve_d;
            is_data_q     <= is_data_d;
            we_q          <= we_d;
            drop_q        <= drop_d;
            mem_en_q      <= mem_en_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_wstrb_q   <= mem_wstrb_d;
            i_rsp_valid_q <= i_rsp_valid_d;
            i_rsp_data_q  <= i_rsp_data_d;
            d_rsp_valid_q <= d_rsp_valid_d;
            d_rsp_data_q  <= d_rsp_data_d;
            busy_q        <= busy_d;
        end
    end

    // Data wins unless fetch has waited through STARVE_LIMIT data grants.
    assign starve_full = (starve_q == SC_W'(STARVE_LIMIT));
    assign d_wins      = bus.d_valid && !(bus.i_valid && starve_full);

    always_comb begin
        state_d       = state_q;
        lat_d         = lat_q;
        starve_d      = starve_q;
        is_data_d     = is_data_q;
        we_d          = we_q;
        drop_d        = drop_q;
        mem_en_d      = 1'b0;
        mem_we_d      = 1'b0;
        mem_addr_d    = '0;
        mem_wdata_d   = '0;
        mem_wstrb_d   = '0;
        i_rsp_valid_d = 1'b0;
        i_rsp_data_d  = i_rsp_data_q;
        d_rsp_valid_d = 1'b0;
        d_rsp_data_d  = d_rsp_data_q;
        i_ready       = 1'b0;
        d_ready       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (rstn) begin
                    if (d_wins) begin
                        d_ready = 1'b1;
                    end else if (bus.i_valid) begin
                        i_ready = 1'b1;
                    end
                end
                if (d_ready) begin
                    state_d     = ISSUE;
                    is_data_d   = 1'b1;
                    we_d        = bus.d_we;
                    drop_d      = 1'b0;
                    mem_en_d    = 1'b1;
                    mem_we_d    = bus.d_we;
                    mem_addr_d  = bus.d_addr;
                    mem_wdata_d = bus.d_wdata;
                    mem_wstrb_d = bus.d_wstrb;
                    if (bus.i_valid && !starve_full) begin
                        starve_d = starve_q + SC_W'(1);
                    end
                end else if (i_ready) begin
                    state_d    = ISSUE;
                    is_data_d  = 1'b0;
                    we_d       = 1'b0;
                    drop_d     = 1'b0;
                    mem_en_d   = 1'b1;
                    mem_addr_d = bus.i_addr;
                    starve_d   = '0;
                end
            end

            ISSUE: begin
                state_d = WAIT;
                lat_d   = LAT_W'(MEM_LATENCY);
                if (!is_data_q && bus.i_flush) begin
                    drop_d = 1'b1;
                end
            end

            WAIT: begin
                lat_d = lat_q - LAT_W'(1);
                if (!is_data_q && bus.i_flush) begin
                    drop_d = 1'b1;
                end
                // lat_q==1 is the mem_rdata valid cycle; a flush seen now still drops.
                if (lat_q == LAT_W'(1)) begin
                    state_d = IDLE;
                    if (is_data_q) begin
                        d_rsp_valid_d = 1'b1;
                        d_rsp_data_d  = we_q ? '0 : bus.mem_rdata;
                    end else if (!(drop_q || bus.i_flush)) begin
                        i_rsp_valid_d = 1'b1;
                        i_rsp_data_d  = bus.mem_rdata;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign bus.i_ready     = i_ready;
    assign bus.d_ready     = d_ready;
    assign bus.i_rsp_valid = i_rsp_valid_q;
    assign bus.i_rsp_data  = i_rsp_data_q;
    assign bus.d_rsp_valid = d_rsp_valid_q;
    assign bus.d_rsp_data  = d_rsp_data_q;
    assign bus.mem_en      = mem_en_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.mem_wstrb   = mem_wstrb_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: one instance at latency 1, one at latency 3.
// Stimulus pushes expected responses, memory strobes and timed checks; one monitor compares.
module tb_mem_port_arbiter;

    typedef enum int {K_IRDY, K_DRDY, K_BUSY, K_IDATA, K_OUTS1, K_OUTS3, K_IRDY3} kind_e;
    typedef struct { int cyc; kind_e k; logic [63:0] exp; } chk_t;
    typedef struct { logic [31:0] data; int cyc; } rsp_t;
    typedef struct { logic [31:0] addr; logic we; logic [31:0] wdata; logic [3:0] wstrb; int cyc; } mem_t;

    logic clk = 1'b0;
    logic rstn;
    int   cyc = 0;
    int   nvec = 0;
    int   nerr = 0;
    bit   done = 1'b0;
    bit   fin  = 1'b0;
    logic [31:0] last_i = '0;

    chk_t cq[$];
    rsp_t iq1[$], dq1[$], iq3[$];
    mem_t mq1[$], mq3[$];

    mem_port_arbiter_if #(.ADDR_W(32)) bus1 ();
    mem_port_arbiter_if #(.ADDR_W(32)) bus3 ();

    mem_port_arbiter #(.MEM_LATENCY(1), .STARVE_LIMIT(4), .ADDR_W(32)) u_dut1 (
        .clk(clk), .rstn(rstn), .bus(bus1)
    );
    mem_port_arbiter #(.MEM_LATENCY(3), .STARVE_LIMIT(4), .ADDR_W(32)) u_dut3 (
        .clk(clk), .rstn(rstn), .bus(bus3)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Latency-1 memory: word i holds A5A5_iiii except word 0x10; byte-strobed writes.
    logic [31:0] mem1 [0:255];
    logic        p1_v = 1'b0;
    logic [31:0] p1_d = '0;
    always @(posedge clk) begin
        if (cyc == 0) begin
            for (int i = 0; i < 256; i++) mem1[i] <= {16'hA5A5, 16'(i)};
            mem1[16] <= 32'h0050_0093;
        end else begin
            p1_v <= bus1.mem_en && !bus1.mem_we;
            p1_d <= mem1[bus1.mem_addr[7:0]];
            if (bus1.mem_en && bus1.mem_we)
                for (int b = 0; b < 4; b++)
                    if (bus1.mem_wstrb[b]) mem1[bus1.mem_addr[7:0]][8*b +: 8] <= bus1.mem_wdata[8*b +: 8];
        end
    end
    assign bus1.mem_rdata = p1_v ? p1_d : 32'hBAD0_BAD0;

    // Latency-3 read-only memory: word a holds C0DE_aaaa.
    logic [2:0]  p3_v = '0;
    logic [31:0] p3_a0 = '0, p3_a1 = '0, p3_a2 = '0;
    always @(posedge clk) begin
        p3_v  <= {p3_v[1:0], bus3.mem_en};
        p3_a0 <= bus3.mem_addr;
        p3_a1 <= p3_a0;
        p3_a2 <= p3_a1;
    end
    assign bus3.mem_rdata = p3_v[2] ? {16'hC0DE, p3_a2[15:0]} : 32'hBAD3_BAD3;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push_chk(input int c, input kind_e k, input logic [63:0] e);
        chk_t it;
        int   pos;
        it.cyc = c; it.k = k; it.exp = e;
        pos = cq.size();
        while (pos > 0 && cq[pos-1].cyc > c) pos--;
        cq.insert(pos, it);
    endtask

    always @(negedge clk) begin : mon
        chk_t        e;
        rsp_t        r;
        mem_t        m;
        logic [63:0] act;
        if (bus1.i_rsp_valid) begin
            if (iq1.size() == 0) chk("i_rsp_unexpected", 64'd1, 64'd0);
            else begin
                r = iq1.pop_front();
                chk("i_rsp_data", bus1.i_rsp_data, r.data);
                chk("i_rsp_cycle", cyc, r.cyc);
            end
        end
        if (bus1.d_rsp_valid) begin
            if (dq1.size() == 0) chk("d_rsp_unexpected", 64'd1, 64'd0);
            else begin
                r = dq1.pop_front();
                chk("d_rsp_data", bus1.d_rsp_data, r.data);
                chk("d_rsp_cycle", cyc, r.cyc);
            end
        end
        if (bus1.mem_en) begin
            if (mq1.size() == 0) chk("mem_en_unexpected", 64'd1, 64'd0);
            else begin
                m = mq1.pop_front();
                chk("mem_access", {bus1.mem_addr, bus1.mem_we, bus1.mem_wstrb, 27'd0},
                    {m.addr, m.we, m.wstrb, 27'd0});
                chk("mem_wdata", bus1.mem_wdata, m.wdata);
                chk("mem_cycle", cyc, m.cyc);
            end
        end else begin
            chk("mem_idle_zero", {bus1.mem_we, |bus1.mem_addr, |bus1.mem_wdata, |bus1.mem_wstrb}, 64'd0);
        end
        chk("one_ready", bus1.i_ready & bus1.d_ready, 64'd0);

        if (bus3.i_rsp_valid) begin
            if (iq3.size() == 0) chk("i_rsp3_unexpected", 64'd1, 64'd0);
            else begin
                r = iq3.pop_front();
                chk("i_rsp3_data", bus3.i_rsp_data, r.data);
                chk("i_rsp3_cycle", cyc, r.cyc);
            end
        end
        if (bus3.d_rsp_valid) chk("d_rsp3_unexpected", 64'd1, 64'd0);
        if (bus3.mem_en) begin
            if (mq3.size() == 0) chk("mem3_en_unexpected", 64'd1, 64'd0);
            else begin
                m = mq3.pop_front();
                chk("mem3_access", {bus3.mem_addr, bus3.mem_we, bus3.mem_wstrb}, {m.addr, m.we, m.wstrb});
                chk("mem3_cycle", cyc, m.cyc);
            end
        end

        while (cq.size() > 0 && cq[0].cyc <= cyc) begin
            e = cq.pop_front();
            if (e.cyc < cyc) chk({"late_", e.k.name()}, 64'd1, 64'd0);
            else begin
                case (e.k)
                    K_IRDY:  act = 64'(bus1.i_ready);
                    K_DRDY:  act = 64'(bus1.d_ready);
                    K_BUSY:  act = 64'(bus1.busy);
                    K_IDATA: act = 64'(bus1.i_rsp_data);
                    K_OUTS1: act = 64'({bus1.busy, bus1.mem_en, bus1.mem_we, |bus1.mem_addr,
                                        |bus1.mem_wdata, |bus1.mem_wstrb, bus1.i_rsp_valid,
                                        |bus1.i_rsp_data, bus1.d_rsp_valid, |bus1.d_rsp_data,
                                        bus1.i_ready, bus1.d_ready});
                    K_OUTS3: act = 64'({bus3.busy, bus3.mem_en, bus3.mem_we, |bus3.mem_addr,
                                        bus3.i_rsp_valid, |bus3.i_rsp_data, bus3.d_rsp_valid,
                                        |bus3.d_rsp_data, bus3.i_ready, bus3.d_ready});
                    default: act = 64'(bus3.i_ready);
                endcase
                chk(e.k.name(), act, e.exp);
            end
        end

        if (done && !fin) begin
            chk("i_rsp_missing", iq1.size(), 64'd0);
            chk("d_rsp_missing", dq1.size(), 64'd0);
            chk("mem_missing", mq1.size(), 64'd0);
            chk("i_rsp3_missing", iq3.size(), 64'd0);
            chk("mem3_missing", mq3.size(), 64'd0);
            chk("checks_pending", cq.size(), 64'd0);
            fin = 1'b1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus1.i_valid = 0; bus1.i_addr = '0; bus1.i_flush = 0;
        bus1.d_valid = 0; bus1.d_we = 0; bus1.d_addr = '0; bus1.d_wdata = '0; bus1.d_wstrb = '0;
        bus3.i_valid = 0; bus3.i_addr = '0; bus3.i_flush = 0;
        bus3.d_valid = 0; bus3.d_we = 0; bus3.d_addr = '0; bus3.d_wdata = '0; bus3.d_wstrb = '0;
    endtask

    // One transaction on the latency-1 instance; fl bits flush in accept/ISSUE/WAIT cycles.
    task automatic xact(input bit is_d, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input logic [31:0] exp, input logic [2:0] fl);
        int   c;
        bit   drop;
        mem_t m;
        rsp_t r;
        c    = cyc;
        drop = !is_d && (fl[1] || fl[2]);
        if (is_d) begin
            bus1.d_valid = 1; bus1.d_we = we; bus1.d_addr = addr; bus1.d_wdata = wdata; bus1.d_wstrb = strb;
        end else begin
            bus1.i_valid = 1; bus1.i_addr = addr;
        end
        bus1.i_flush = fl[0];
        push_chk(c, is_d ? K_DRDY : K_IRDY, 64'd1);
        push_chk(c + 1, K_BUSY, 64'd1);
        push_chk(c + 2, K_BUSY, 64'd1);
        push_chk(c + 3, K_BUSY, 64'd0);
        m.addr = addr; m.we = is_d && we; m.wdata = is_d ? wdata : '0; m.wstrb = is_d ? strb : '0;
        m.cyc = c + 1;
        mq1.push_back(m);
        r.cyc = c + 3; r.data = exp;
        if (is_d) dq1.push_back(r);
        else if (!drop) begin
            iq1.push_back(r);
            last_i = exp;
        end else push_chk(c + 3, K_IDATA, 64'(last_i));
        step();
        bus1.i_valid = 0; bus1.d_valid = 0; bus1.d_we = 0; bus1.d_wdata = '0; bus1.d_wstrb = '0;
        bus1.i_flush = fl[1];
        step();
        bus1.i_flush = fl[2];
        step();
        bus1.i_flush = 0;
        step();
    endtask

    task automatic contention();
        int          s, g;
        logic [9:0]  pat_i;
        mem_t        m;
        rsp_t        r;
        pat_i = 10'b10_0001_0000;
        s = cyc;
        bus1.i_valid = 1; bus1.i_addr = 32'h20;
        bus1.d_valid = 1; bus1.d_we = 0; bus1.d_addr = 32'h30;
        for (int k = 0; k < 10; k++) begin
            g = s + 3 * k;
            push_chk(g, K_IRDY, 64'(pat_i[k]));
            push_chk(g, K_DRDY, 64'(!pat_i[k]));
            push_chk(g + 1, K_IRDY, 64'd0);
            push_chk(g + 1, K_DRDY, 64'd0);
            push_chk(g + 2, K_IRDY, 64'd0);
            push_chk(g + 2, K_DRDY, 64'd0);
            m.addr = pat_i[k] ? 32'h20 : 32'h30; m.we = 0; m.wdata = '0; m.wstrb = '0; m.cyc = g + 1;
            mq1.push_back(m);
            r.cyc = g + 3;
            if (pat_i[k]) begin r.data = 32'hA5A5_0020; iq1.push_back(r); end
            else begin r.data = 32'hA5A5_0030; dq1.push_back(r); end
        end
        repeat (28) step();
        bus1.i_valid = 0; bus1.d_valid = 0;
        last_i = 32'hA5A5_0020;
        repeat (3) step();
    endtask

    task automatic sweep();
        int   s;
        mem_t m;
        rsp_t r;
        s = cyc;
        bus3.i_valid = 1; bus3.i_addr = 32'h40;
        for (int k = 0; k < 3; k++) begin
            push_chk(s + 5 * k, K_IRDY3, 64'd1);
            for (int j = 1; j < 5; j++) push_chk(s + 5 * k + j, K_IRDY3, 64'd0);
            m.addr = 32'h40 + 32'(k); m.we = 0; m.wdata = '0; m.wstrb = '0; m.cyc = s + 5 * k + 1;
            mq3.push_back(m);
            r.data = {16'hC0DE, 16'h0040 + 16'(k)}; r.cyc = s + 5 * k + 5;
            iq3.push_back(r);
        end
        step();
        bus3.i_addr = 32'h41;
        repeat (5) step();
        bus3.i_addr = 32'h42;
        repeat (5) step();
        bus3.i_valid = 0;
        repeat (5) step();
    endtask

    task automatic reset_mid();
        int   c;
        mem_t m;
        c = cyc;
        bus1.i_valid = 1; bus1.i_addr = 32'h14;
        push_chk(c, K_IRDY, 64'd1);
        push_chk(c + 1, K_BUSY, 64'd1);
        m.addr = 32'h14; m.we = 0; m.wdata = '0; m.wstrb = '0; m.cyc = c + 1;
        mq1.push_back(m);
        step();
        bus1.i_valid = 0;
        step();
        rstn = 0;
        step();
        bus1.d_valid = 1; bus1.d_we = 0; bus1.d_addr = 32'h30;
        push_chk(c + 3, K_OUTS1, 64'd0);
        step();
        rstn = 1;
        last_i = '0;
        xact(1, 0, 32'h30, '0, 4'h0, 32'hA5A5_0030, 3'b000);
    endtask

    initial begin
        rstn = 0;
        idle_inputs();
        bus1.i_valid = 1; bus1.d_valid = 1; bus3.i_valid = 1;
        push_chk(1, K_OUTS1, 64'd0);
        push_chk(2, K_OUTS1, 64'd0);
        push_chk(2, K_OUTS3, 64'd0);
        repeat (3) step();
        idle_inputs();
        rstn = 1;
        step();

        xact(0, 0, 32'h10, '0, 4'h0, 32'h0050_0093, 3'b000);
        xact(1, 1, 32'h05, 32'hDEAD_BEEF, 4'hF, 32'h0, 3'b000);
        xact(1, 0, 32'h05, '0, 4'h0, 32'hDEAD_BEEF, 3'b000);
        xact(1, 1, 32'h06, 32'h1122_3344, 4'b0101, 32'h0, 3'b000);
        xact(1, 0, 32'h06, '0, 4'h0, 32'hA522_0044, 3'b000);

        contention();

        xact(0, 0, 32'h11, '0, 4'h0, 32'hA5A5_0011, 3'b100);
        xact(0, 0, 32'h15, '0, 4'h0, 32'hA5A5_0015, 3'b010);
        xact(0, 0, 32'h12, '0, 4'h0, 32'hA5A5_0012, 3'b000);
        xact(0, 0, 32'h13, '0, 4'h0, 32'hA5A5_0013, 3'b001);
        xact(1, 0, 32'h30, '0, 4'h0, 32'hA5A5_0030, 3'b110);

        sweep();
        reset_mid();

        repeat (8) step();
        done = 1'b1;
        repeat (3) step();
        if (!fin) begin
            nerr++;
            $display("FAIL final_drain: got fin=0, expected fin=1");
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
